// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO.
package sync_fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    // Width of an occupancy count that can hold 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Only the read register clears; the array itself is never reset.
module sync_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read of the address being written returns the old contents.
    always_ff @(posedge CLK) begin
        if (rd_clr) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through output,
// occupancy count, almost flags, synchronous flush and sticky error flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         DEPTH     = 16,
    parameter fifo_mode_e MODE      = FIFO_STD,
    parameter int         AF_THRESH = DEPTH - 2,
    parameter int         AE_THRESH = 2
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          din,
    input  logic                      wr_en,
    output logic                      wr_rdy,
    output logic                      full,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic                      rd_rdy,
    output logic [WIDTH-1:0]          dout,
    output logic                      empty,
    output logic                      almost_empty,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]    level_reg, level_next;
    logic             full_reg, empty_reg, af_reg, ae_reg;
    logic             overflow_reg, underflow_reg;
    logic             clear, wr_acc, rd_acc;
    logic             ram_rd_en;
    logic [PW-1:0]    ram_rd_addr;
    logic [WIDTH-1:0] ram_rd_data;

    assign clear  = reset | flush;
    assign wr_acc = wr_en & ~full_reg  & ~clear;
    assign rd_acc = rd_en & ~empty_reg & ~clear;

    always_comb begin
        wr_ptr_next = wr_acc ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = rd_acc ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        level_next  = level_reg;
        case ({wr_acc, rd_acc})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end
    end

    // Flags are registered from the next level so they track the edge just taken.
    always_ff @(posedge CLK) begin
        if (clear) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            af_reg        <= 1'b0;
            ae_reg        <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            full_reg   <= (level_next == FULL_LVL);
            empty_reg  <= (level_next == '0);
            af_reg     <= (level_next >= AF_LVL);
            ae_reg     <= (level_next <= AE_LVL);
            if (wr_en && full_reg) begin
                overflow_reg <= 1'b1;
            end
            if (rd_en && empty_reg) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (din),
        .rd_en   (ram_rd_en),
        .rd_clr  (clear),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            logic             bypass_sel_reg;
            logic [WIDTH-1:0] bypass_data_reg;

            // The RAM always prefetches the post-edge head; when that head is
            // the word being written this edge, the RAM returns stale data,
            // so the incoming word is captured alongside and selected instead.
            always_ff @(posedge CLK) begin
                if (clear) begin
                    bypass_sel_reg  <= 1'b0;
                    bypass_data_reg <= '0;
                end else begin
                    bypass_sel_reg  <= wr_acc && (level_reg == LW'(rd_acc));
                    bypass_data_reg <= din;
                end
            end

            assign ram_rd_en   = 1'b1;
            assign ram_rd_addr = rd_ptr_next;
            assign dout        = bypass_sel_reg ? bypass_data_reg : ram_rd_data;
        end else begin : g_std
            assign ram_rd_en   = rd_acc;
            assign ram_rd_addr = rd_ptr_reg;
            assign dout        = ram_rd_data;
        end
    endgenerate

    assign wr_rdy       = ~full_reg;
    assign full         = full_reg;
    assign almost_full  = af_reg;
    assign rd_rdy       = ~empty_reg;
    assign empty        = empty_reg;
    assign almost_empty = ae_reg;
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one STD instance and one FWFT instance.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // STD instance
    logic        s_reset = 1'b0, s_flush = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [31:0] s_din = '0, s_dout;
    logic        s_wr_rdy, s_full, s_almost_full, s_rd_rdy, s_empty, s_almost_empty;
    logic        s_overflow, s_underflow;
    logic [4:0]  s_level;

    // FWFT instance
    logic        f_reset = 1'b0, f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [31:0] f_din = '0, f_dout;
    logic        f_wr_rdy, f_full, f_almost_full, f_rd_rdy, f_empty, f_almost_empty;
    logic        f_overflow, f_underflow;
    logic [4:0]  f_level;

    sync_fifo #(.WIDTH(32), .DEPTH(16), .MODE(FIFO_STD)) u_std (
        .CLK(CLK), .reset(s_reset), .flush(s_flush), .din(s_din), .wr_en(s_wr_en),
        .wr_rdy(s_wr_rdy), .full(s_full), .almost_full(s_almost_full), .rd_en(s_rd_en),
        .rd_rdy(s_rd_rdy), .dout(s_dout), .empty(s_empty), .almost_empty(s_almost_empty),
        .level(s_level), .overflow(s_overflow), .underflow(s_underflow)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(16), .MODE(FIFO_FWFT)) u_fwft (
        .CLK(CLK), .reset(f_reset), .flush(f_flush), .din(f_din), .wr_en(f_wr_en),
        .wr_rdy(f_wr_rdy), .full(f_full), .almost_full(f_almost_full), .rd_en(f_rd_en),
        .rd_rdy(f_rd_rdy), .dout(f_dout), .empty(f_empty), .almost_empty(f_almost_empty),
        .level(f_level), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        s_reset = 1'b1; f_reset = 1'b1;
        step();
        s_reset = 1'b0; f_reset = 1'b0;
        checks++;
        if ({s_wr_rdy, s_full, s_almost_full, s_rd_rdy, s_empty, s_almost_empty, s_overflow, s_underflow} !== 8'b10001100) begin
            errors++;
            $display("FAIL reset_flags_std got=%b exp=10001100",
                     {s_wr_rdy, s_full, s_almost_full, s_rd_rdy, s_empty, s_almost_empty, s_overflow, s_underflow});
        end
        checks++;
        if (s_level !== 5'd0 || s_dout !== 32'd0) begin
            errors++;
            $display("FAIL reset_level_dout_std level=%0d dout=%h exp level=0 dout=0", s_level, s_dout);
        end
        checks++;
        if ({f_wr_rdy, f_full, f_almost_full, f_rd_rdy, f_empty, f_almost_empty, f_overflow, f_underflow} !== 8'b10001100
            || f_level !== 5'd0 || f_dout !== 32'd0) begin
            errors++;
            $display("FAIL reset_fwft flags=%b level=%0d dout=%h exp flags=10001100 level=0 dout=0",
                     {f_wr_rdy, f_full, f_almost_full, f_rd_rdy, f_empty, f_almost_empty, f_overflow, f_underflow},
                     f_level, f_dout);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            s_din = 32'(i); s_wr_en = 1'b1;
            step();
            checks++;
            if (s_level !== 5'(i + 1) || s_full !== (i == 15) || s_almost_full !== (i >= 13)
                || s_almost_empty !== (i <= 1) || s_rd_rdy !== 1'b1) begin
                errors++;
                $display("FAIL fill_%0d level=%0d full=%b af=%b ae=%b rd_rdy=%b exp level=%0d full=%b af=%b ae=%b rd_rdy=1",
                         i, s_level, s_full, s_almost_full, s_almost_empty, s_rd_rdy,
                         i + 1, (i == 15), (i >= 13), (i <= 1));
            end
        end
        s_wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1'b1;
            step();
            $display("std rd %0d dout=%h", i, s_dout);
            checks++;
            if (s_dout !== 32'(i) || s_level !== 5'(15 - i) || s_full !== 1'b0) begin
                errors++;
                $display("FAIL drain_%0d dout=%h level=%0d full=%b exp dout=%h level=%0d full=0",
                         i, s_dout, s_level, s_full, i, 15 - i);
            end
        end
        s_rd_en = 1'b0;
        checks++;
        if (s_empty !== 1'b1 || s_rd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty empty=%b rd_rdy=%b exp empty=1 rd_rdy=0", s_empty, s_rd_rdy);
        end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 16; i++) begin
            s_din = 32'(100 + i); s_wr_en = 1'b1;
            step();
        end
        s_din = 32'hDEAD;
        step();
        s_wr_en = 1'b0;
        checks++;
        if (s_overflow !== 1'b1 || s_level !== 5'd16 || s_wr_rdy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_set ovf=%b level=%0d wr_rdy=%b exp ovf=1 level=16 wr_rdy=0",
                     s_overflow, s_level, s_wr_rdy);
        end
        step();
        checks++;
        if (s_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky ovf=%b exp 1", s_overflow);
        end
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1'b1;
            step();
            checks++;
            if (s_dout !== 32'(100 + i)) begin
                errors++;
                $display("FAIL ovf_drain_%0d dout=%h exp %h", i, s_dout, 100 + i);
            end
        end
        checks++;
        if (s_underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_early udf=%b exp 0", s_underflow);
        end
        step();
        s_rd_en = 1'b0;
        checks++;
        if (s_underflow !== 1'b1 || s_dout !== 32'd115 || s_level !== 5'd0) begin
            errors++;
            $display("FAIL underflow_set udf=%b dout=%h level=%0d exp udf=1 dout=00000073 level=0",
                     s_underflow, s_dout, s_level);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            s_din = 32'(300 + i); s_wr_en = 1'b1;
            step();
        end
        checks++;
        if (s_level !== 5'd5 || s_overflow !== 1'b1 || s_underflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_flush level=%0d ovf=%b udf=%b exp level=5 ovf=1 udf=1",
                     s_level, s_overflow, s_underflow);
        end
        s_flush = 1'b1; s_din = 32'h77;
        step();
        s_flush = 1'b0; s_wr_en = 1'b0;
        checks++;
        if (s_level !== 5'd0 || s_empty !== 1'b1 || s_dout !== 32'd0
            || s_overflow !== 1'b0 || s_underflow !== 1'b0) begin
            errors++;
            $display("FAIL flush level=%0d empty=%b dout=%h ovf=%b udf=%b exp 0 1 0 0 0",
                     s_level, s_empty, s_dout, s_overflow, s_underflow);
        end
        step();
        checks++;
        if (s_level !== 5'd0 || s_rd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_write_lost level=%0d rd_rdy=%b exp level=0 rd_rdy=0", s_level, s_rd_rdy);
        end
        s_din = 32'h55; s_wr_en = 1'b1;
        step();
        s_wr_en = 1'b0; s_rd_en = 1'b1;
        step();
        s_rd_en = 1'b0;
        checks++;
        if (s_dout !== 32'h55 || s_empty !== 1'b1) begin
            errors++;
            $display("FAIL post_flush_data dout=%h empty=%b exp dout=00000055 empty=1", s_dout, s_empty);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            s_din = 32'(400 + i); s_wr_en = 1'b1;
            step();
        end
        checks++;
        if (s_level !== 5'd8) begin
            errors++;
            $display("FAIL b2b_prefill level=%0d exp 8", s_level);
        end
        for (int k = 0; k < 20; k++) begin
            s_din = 32'(408 + k); s_wr_en = 1'b1; s_rd_en = 1'b1;
            step();
            $display("b2b rd %0d dout=%h level=%0d", k, s_dout, s_level);
            checks++;
            if (s_dout !== 32'(400 + k) || s_level !== 5'd8) begin
                errors++;
                $display("FAIL b2b_%0d dout=%h level=%0d exp dout=%h level=8", k, s_dout, s_level, 400 + k);
            end
        end
        s_wr_en = 1'b0; s_rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        s_din = 32'h999; s_wr_en = 1'b1;
        step();
        s_wr_en = 1'b0;
        checks++;
        if (s_level !== 5'd9) begin
            errors++;
            $display("FAIL pre_reset level=%0d exp 9", s_level);
        end
        s_reset = 1'b1;
        step();
        s_reset = 1'b0;
        checks++;
        if ({s_wr_rdy, s_full, s_almost_full, s_rd_rdy, s_empty, s_almost_empty, s_overflow, s_underflow} !== 8'b10001100
            || s_level !== 5'd0 || s_dout !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid flags=%b level=%0d dout=%h exp flags=10001100 level=0 dout=0",
                     {s_wr_rdy, s_full, s_almost_full, s_rd_rdy, s_empty, s_almost_empty, s_overflow, s_underflow},
                     s_level, s_dout);
        end
    endtask

    task automatic test_fwft();
        f_din = 32'hA5; f_wr_en = 1'b1;
        step();
        f_wr_en = 1'b0;
        checks++;
        if (f_rd_rdy !== 1'b1 || f_dout !== 32'hA5 || f_level !== 5'd1) begin
            errors++;
            $display("FAIL fwft_bypass rd_rdy=%b dout=%h level=%0d exp 1 000000a5 1", f_rd_rdy, f_dout, f_level);
        end
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        checks++;
        if (f_rd_rdy !== 1'b0 || f_empty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_pop_last rd_rdy=%b empty=%b exp 0 1", f_rd_rdy, f_empty);
        end
        for (int i = 1; i <= 3; i++) begin
            f_din = 32'(i); f_wr_en = 1'b1;
            step();
            checks++;
            if (f_dout !== 32'd1) begin
                errors++;
                $display("FAIL fwft_head_%0d dout=%h exp 00000001", i, f_dout);
            end
        end
        f_wr_en = 1'b0;
        for (int i = 2; i <= 3; i++) begin
            f_rd_en = 1'b1;
            step();
            $display("fwft rd dout=%h", f_dout);
            checks++;
            if (f_dout !== 32'(i) || f_rd_rdy !== 1'b1) begin
                errors++;
                $display("FAIL fwft_next_%0d dout=%h rd_rdy=%b exp %h 1", i, f_dout, f_rd_rdy, i);
            end
        end
        f_din = 32'd4; f_wr_en = 1'b1; f_rd_en = 1'b1;
        step();
        f_wr_en = 1'b0;
        checks++;
        if (f_dout !== 32'd4 || f_level !== 5'd1 || f_rd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL fwft_rw_level1 dout=%h level=%0d rd_rdy=%b exp 00000004 1 1", f_dout, f_level, f_rd_rdy);
        end
        step();
        f_rd_en = 1'b0;
        checks++;
        if (f_empty !== 1'b1 || f_rd_rdy !== 1'b0 || f_underflow !== 1'b0) begin
            errors++;
            $display("FAIL fwft_final empty=%b rd_rdy=%b udf=%b exp 1 0 0", f_empty, f_rd_rdy, f_underflow);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_fwft();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
